// File: rtl/adc_sequencer.sv
// SAR ADC conversion sequencer: generates init/sample/compare/update
// timing, collects comparator decisions and hands out the result word.
module adc_sequencer #(
    parameter int NCYC     = 16,
    parameter int SAMP_LEN = 4,
    parameter int COMP_LEN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cont,
    input  logic            comp_out,
    input  logic            result_ready,
    output logic            seq_init,
    output logic            seq_samp,
    output logic            seq_comp,
    output logic            seq_update,
    output logic            busy,
    output logic [NCYC-1:0] result,
    output logic            result_valid,
    output logic            overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SAMP,
        S_COMP,
        S_UPDATE
    } state_t;

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [4:0]       idx_q;
    logic [NCYC-1:0]  sr_q;
    logic             init_q;
    logic             samp_q;
    logic             comp_q;
    logic             upd_q;

    logic [NCYC-1:0]  result_q;
    logic [NCYC-1:0]  result_d;
    logic             valid_q;
    logic             valid_d;
    logic             overrun_q;
    logic             overrun_d;

    logic             last_bit;
    logic             load;

    assign last_bit = (idx_q == 5'(NCYC-1));
    assign load     = (state_q == S_UPDATE) && last_bit;

    // Phase FSM; seq_* flops are set together with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            init_q  <= 1'b0;
            samp_q  <= 1'b0;
            comp_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_INIT;
                        init_q  <= 1'b1;
                        sr_q    <= '0;
                    end
                end
                S_INIT: begin
                    state_q <= S_SAMP;
                    init_q  <= 1'b0;
                    samp_q  <= 1'b1;
                    cnt_q   <= 8'(SAMP_LEN-1);
                end
                S_SAMP: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= S_COMP;
                        samp_q  <= 1'b0;
                        comp_q  <= 1'b1;
                        cnt_q   <= 8'(COMP_LEN-1);
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_COMP: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= S_UPDATE;
                        comp_q  <= 1'b0;
                        upd_q   <= 1'b1;
                        for (int i = 0; i < NCYC; i++) begin
                            if (idx_q == 5'(NCYC-1-i)) begin
                                sr_q[i] <= comp_out;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_UPDATE: begin
                    upd_q <= 1'b0;
                    if (!last_bit) begin
                        state_q <= S_COMP;
                        comp_q  <= 1'b1;
                        cnt_q   <= 8'(COMP_LEN-1);
                        idx_q   <= idx_q + 5'd1;
                    end else if (cont) begin
                        state_q <= S_INIT;
                        init_q  <= 1'b1;
                        sr_q    <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    init_q  <= 1'b0;
                    samp_q  <= 1'b0;
                    comp_q  <= 1'b0;
                    upd_q   <= 1'b0;
                end
            endcase
        end
    end

    // Result handoff: a load wins over an accept on the same edge
    always_comb begin
        result_d  = result_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            result_d = sr_q;
            valid_d  = 1'b1;
            if (valid_q && !result_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end
    end

    // Result, valid and sticky overrun registers
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign seq_init     = init_q;
    assign seq_samp     = samp_q;
    assign seq_comp     = comp_q;
    assign seq_update   = upd_q;
    assign busy         = (state_q != S_IDLE);
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: default and minimal configurations driven
// by shared stimulus and compared each cycle against a timeline model.
module tb_adc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, cont, comp_out, result_ready;

    logic        a_init, a_samp, a_comp, a_upd, a_busy, a_valid, a_ovr;
    logic [15:0] a_res;
    logic        b_init, b_samp, b_comp, b_upd, b_busy, b_valid, b_ovr;
    logic [0:0]  b_res;

    adc_sequencer #(.NCYC(16), .SAMP_LEN(4), .COMP_LEN(2)) u_a (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .comp_out(comp_out), .result_ready(result_ready),
        .seq_init(a_init), .seq_samp(a_samp), .seq_comp(a_comp),
        .seq_update(a_upd), .busy(a_busy), .result(a_res),
        .result_valid(a_valid), .overrun(a_ovr)
    );

    adc_sequencer #(.NCYC(1), .SAMP_LEN(1), .COMP_LEN(1)) u_b (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .comp_out(comp_out), .result_ready(result_ready),
        .seq_init(b_init), .seq_samp(b_samp), .seq_comp(b_comp),
        .seq_update(b_upd), .busy(b_busy), .result(b_res),
        .result_valid(b_valid), .overrun(b_ovr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: each unit is a position in the conversion timeline (-1 = idle)
    int cN [2] = '{16, 1};
    int cS [2] = '{4, 1};
    int cC [2] = '{2, 1};

    int          m_pos [2] = '{-1, -1};
    logic [15:0] m_sr  [2] = '{16'h0, 16'h0};
    logic [15:0] m_res [2] = '{16'h0, 16'h0};
    logic        m_val [2] = '{1'b0, 1'b0};
    logic        m_ovr [2] = '{1'b0, 1'b0};

    function automatic int clen(int u);
        return 1 + cS[u] + cN[u] * (cC[u] + 1);
    endfunction

    // 0 idle, 1 init, 2 samp, 3 comp, 4 update
    function automatic int phase(int u, int p);
        int j;
        if (p < 0) return 0;
        if (p == 0) return 1;
        if (p <= cS[u]) return 2;
        j = p - 1 - cS[u];
        return (j % (cC[u] + 1) < cC[u]) ? 3 : 4;
    endfunction

    function automatic int bitno(int u, int p);
        return (p - 1 - cS[u]) / (cC[u] + 1);
    endfunction

    function automatic logic [3:0] exp_seq(int u);
        case (phase(u, m_pos[u]))
            1: return 4'b1000;
            2: return 4'b0100;
            3: return 4'b0010;
            4: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_step(int u);
        int p;
        int nxt;
        p = m_pos[u];
        if (rst) begin
            m_pos[u] = -1;
            m_sr[u]  = '0;
            m_res[u] = '0;
            m_val[u] = 1'b0;
            m_ovr[u] = 1'b0;
        end else begin
            if (phase(u, p) == 3 &&
                (p - 1 - cS[u]) % (cC[u] + 1) == cC[u] - 1)
                m_sr[u][cN[u] - 1 - bitno(u, p)] = comp_out;
            if (p == clen(u) - 1) begin
                if (m_val[u] && !result_ready) m_ovr[u] = 1'b1;
                m_res[u] = m_sr[u];
                m_val[u] = 1'b1;
            end else if (m_val[u] && result_ready) begin
                m_val[u] = 1'b0;
            end
            if (p < 0) nxt = start ? 0 : -1;
            else if (p < clen(u) - 1) nxt = p + 1;
            else nxt = cont ? 0 : -1;
            if (nxt == 0) m_sr[u] = '0;
            m_pos[u] = nxt;
        end
    endtask

    task automatic compare_all();
        logic [3:0]  sq;
        logic [15:0] rs;
        logic        bz, vl, ov;
        for (int u = 0; u < 2; u++) begin
            if (u == 0) begin
                sq = {a_init, a_samp, a_comp, a_upd};
                rs = a_res; bz = a_busy; vl = a_valid; ov = a_ovr;
            end else begin
                sq = {b_init, b_samp, b_comp, b_upd};
                rs = {15'h0, b_res}; bz = b_busy; vl = b_valid; ov = b_ovr;
            end
            check($sformatf("u%0d seq", u), 32'(sq), 32'(exp_seq(u)));
            check($sformatf("u%0d excl", u), 32'($countones(sq) > 1), 0);
            check($sformatf("u%0d busy", u), 32'(bz), 32'(m_pos[u] >= 0));
            check($sformatf("u%0d result", u), 32'(rs), 32'(m_res[u]));
            check($sformatf("u%0d valid", u), 32'(vl), 32'(m_val[u]));
            check($sformatf("u%0d overrun", u), 32'(ov), 32'(m_ovr[u]));
        end
    endtask

    // comp_out policy: 0 random, 1 zero, 2 one, 3 alternate per decision
    int cmode = 1;

    task automatic cyc();
        int p;
        p = m_pos[0];
        case (cmode)
            0: comp_out = 1'($urandom);
            1: comp_out = 1'b0;
            2: comp_out = 1'b1;
            default:
                comp_out = (phase(0, p) == 3) ? (bitno(0, p) % 2 == 0) : 1'b1;
        endcase
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    int cnt, ni, ns, nc, nu, nres, links;
    logic prev_upd;

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0;
        result_ready = 1'b0; comp_out = 1'b0;

        // reset state and idle hold
        cyc(); cyc();
        check("rst busy", 32'(a_busy), 0);
        check("rst result", 32'(a_res), 0);
        rst = 1'b0;
        repeat (4) cyc();
        check("idle hold", 32'(a_busy), 0);

        // single conversion, alternating decisions
        cmode = 3;
        start = 1'b1; cyc(); start = 1'b0;
        cnt = a_busy; ni = a_init; ns = 0; nc = 0; nu = 0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            cnt += a_busy; ni += a_init; ns += a_samp;
            nc += a_comp; nu += a_upd;
            if (k == 52) begin
                check("single valid", 32'(a_valid), 1);
                check("single result", 32'(a_res), 32'h0000AAAA);
                check("single busy", 32'(a_busy), 0);
            end
        end
        check("single len", cnt, 53);
        check("single init", ni, 1);
        check("single samp", ns, 4);
        check("single comp", nc, 32);
        check("single upd", nu, 16);
        result_ready = 1'b1; cyc();
        check("accept", 32'(a_valid), 0);
        result_ready = 1'b0;

        // continuous mode
        cmode = 2; cont = 1'b1; result_ready = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        nres = 0; links = 0; prev_upd = a_upd;
        for (int k = 0; k < 159; k++) begin
            cyc();
            if (a_valid && a_res == 16'hFFFF) nres++;
            if (prev_upd && a_init) links++;
            prev_upd = a_upd;
        end
        check("cont results", nres, 3);
        check("cont links", links, 3);
        check("cont overrun", 32'(a_ovr), 0);
        cont = 1'b0;
        repeat (60) cyc();
        result_ready = 1'b0;

        // overrun
        rst = 1'b1; cyc(); rst = 1'b0;
        cmode = 1; cont = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (53) cyc();
        check("ovr first", 32'(a_res), 32'h0000);
        check("ovr first flag", 32'(a_ovr), 0);
        cmode = 2; cont = 1'b0;
        repeat (53) cyc();
        check("ovr second", 32'(a_res), 32'hFFFF);
        check("ovr flag", 32'(a_ovr), 1);
        check("ovr valid", 32'(a_valid), 1);

        // accept on the load edge
        rst = 1'b1; cyc(); rst = 1'b0;
        cmode = 0;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (53) cyc();
        check("sim pre valid", 32'(a_valid), 1);
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 53; k++) begin
            result_ready = (m_pos[0] == clen(0) - 1);
            cyc();
        end
        result_ready = 1'b0;
        check("sim valid", 32'(a_valid), 1);
        check("sim overrun", 32'(a_ovr), 0);

        // reset during the 5th comparison
        rst = 1'b1; cyc(); rst = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cnt = 0;
        while (m_pos[0] != 17 && cnt < 100) begin
            cyc(); cnt++;
        end
        check("mid reach", 32'(m_pos[0]), 17);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("mid seq",
              32'({a_init, a_samp, a_comp, a_upd}), 0);
        check("mid busy", 32'(a_busy), 0);
        check("mid result", 32'(a_res), 0);
        check("mid valid", 32'(a_valid), 0);
        start = 1'b1; cyc(); start = 1'b0;
        cnt = a_busy;
        for (int k = 0; k < 55; k++) begin
            cyc(); cnt += a_busy;
        end
        check("mid len", cnt, 53);
        check("mid done", 32'(a_valid), 1);

        // minimal configuration
        rst = 1'b1; cyc(); rst = 1'b0;
        cmode = 2;
        start = 1'b1; cyc(); start = 1'b0;
        cnt = b_busy;
        repeat (5) begin
            cyc(); cnt += b_busy;
        end
        check("min len", cnt, 4);
        check("min result", 32'(b_res), 1);
        check("min valid", 32'(b_valid), 1);

        // random traffic
        cmode = 0;
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom_range(0, 199) == 0);
            start        = ($urandom_range(0, 3) == 0);
            cont         = ($urandom_range(0, 2) == 0);
            result_ready = 1'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
